hd_timing: RTL and testbench

HD_TIMING -- requirements
Module: hd_timing

---
 rtl/hd_timing_if.sv | 36 +++
 rtl/hd_timing.sv | 115 +++++++++++
 tb/tb_hd_timing.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/hd_timing_if.sv
// Controller <-> beat/phase sequencer signal bundle.
// HD_TIMING_SSTEP_EN adds the single-step request line.
interface hd_timing_if;
    logic       start;
    logic       short;
    logic       long;
    logic       stop;
`ifdef HD_TIMING_SSTEP_EN
    logic       sstep;
`endif
    logic [3:1] w;
    logic       t1;
    logic       t2;
    logic       t3;
    logic       run;

`ifdef HD_TIMING_SSTEP_EN
    modport master (
        output start, short, long, stop, sstep,
        input  w, t1, t2, t3, run
    );
    modport slave (
        input  start, short, long, stop, sstep,
        output w, t1, t2, t3, run
    );
`else
    modport master (
        output start, short, long, stop,
        input  w, t1, t2, t3, run
    );
    modport slave (
        input  start, short, long, stop,
        output w, t1, t2, t3, run
    );
`endif
endinterface

// File: rtl/hd_timing.sv
// Beat (W) / phase (T1..T3) timing sequencer with START edge detect and STOP halt.
// Optional single-step mode under HD_TIMING_SSTEP_EN.
module hd_timing (
    input  logic       clk,
    input  logic       clr,
    hd_timing_if.slave bus
);

    // Phase state is the T strobe vector itself, so outputs come straight from flops.
    typedef enum logic [2:0] {
        StIdle = 3'b000,
        StT1   = 3'b001,
        StT2   = 3'b010,
        StT3   = 3'b100
    } phase_e;

    phase_e     t_q, t_d;
    logic [3:1] w_q, w_d;
    logic       run_q, run_d;
    logic       start_q;

    logic       start_edge;
    logic       halt_req;
    logic       w_legal;
    logic [3:1] w_adv;

    assign start_edge = bus.start & ~start_q;

`ifdef HD_TIMING_SSTEP_EN
    assign halt_req = bus.stop | bus.sstep;
`else
    assign halt_req = bus.stop;
`endif

    assign w_legal = (w_q == 3'b001) || (w_q == 3'b010) || (w_q == 3'b100);

    // State register. Edge history is preset high so a START held through CLR is not an edge.
    always_ff @(posedge clk) begin
        if (clr) begin
            t_q     <= StIdle;
            w_q     <= 3'b001;
            run_q   <= 1'b0;
            start_q <= 1'b1;
        end else begin
            t_q     <= t_d;
            w_q     <= w_d;
            run_q   <= run_d;
            start_q <= bus.start;
        end
    end

    // Beat successor, only consumed on the edge leaving T3.
    always_comb begin
        w_adv = 3'b001;
        case (w_q)
            3'b001:  w_adv = bus.short ? 3'b001 : 3'b010;
            3'b010:  w_adv = bus.long  ? 3'b100 : 3'b001;
            3'b100:  w_adv = 3'b001;
            default: w_adv = 3'b001;
        endcase
    end

    // Next state. Any T/RUN combination that is not legal falls back to halted.
    always_comb begin
        t_d   = t_q;
        w_d   = w_q;
        run_d = run_q;
        case (t_q)
            StIdle: begin
                if (run_q) begin
                    run_d = 1'b0;
                end else if (start_edge) begin
                    t_d   = StT1;
                    run_d = 1'b1;
                end
            end
            StT1: begin
                t_d   = run_q ? StT2 : StIdle;
            end
            StT2: begin
                t_d   = run_q ? StT3 : StIdle;
            end
            StT3: begin
                if (run_q) begin
                    w_d = w_adv;
                    if (halt_req) begin
                        t_d   = StIdle;
                        run_d = 1'b0;
                    end else begin
                        t_d   = StT1;
                    end
                end else begin
                    t_d = StIdle;
                end
            end
            default: begin
                t_d   = StIdle;
                run_d = 1'b0;
            end
        endcase
        if (!w_legal) begin
            w_d = 3'b001;
        end
    end

    // Outputs are pure register taps.
    always_comb begin
        bus.w   = w_q;
        bus.t1  = t_q[0];
        bus.t2  = t_q[1];
        bus.t3  = t_q[2];
        bus.run = run_q;
    end

endmodule

// File: tb/tb_hd_timing.sv
// Self-checking bench for hd_timing: directed scenarios plus random stimulus
// against a cycle-level beat/phase reference model.
module tb_hd_timing;

    logic clk = 1'b0;
    logic clr;

    hd_timing_if bus ();

    hd_timing dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: beat number 1..3, phase 0 (halted) or 1..3, run flag, last START.
    int m_beat;
    int m_phase;
    bit m_run;
    bit m_prev;

    task automatic check();
        logic [2:0] exp_w;
        logic [2:0] exp_t;
        logic [2:0] got_t;
        exp_w = 3'b001 << (m_beat - 1);
        exp_t = (m_phase == 0) ? 3'b000 : (3'b001 << (m_phase - 1));
        got_t = {bus.t3, bus.t2, bus.t1};
        tests++;
        assert (bus.w === exp_w) else begin
            fails++;
            $error("FAIL w: got %b expected %b (t=%0t)", bus.w, exp_w, $time);
        end
        tests++;
        assert (got_t === exp_t) else begin
            fails++;
            $error("FAIL t: got %b expected %b (t=%0t)", got_t, exp_t, $time);
        end
        tests++;
        assert (bus.run === m_run) else begin
            fails++;
            $error("FAIL run: got %b expected %b (t=%0t)", bus.run, m_run, $time);
        end
    endtask

    task automatic tick();
        bit st_edge;
        bit halt;
        @(posedge clk);
        halt = bus.stop;
`ifdef HD_TIMING_SSTEP_EN
        halt = halt | bus.sstep;
`endif
        if (clr) begin
            m_beat  = 1;
            m_phase = 0;
            m_run   = 1'b0;
            m_prev  = 1'b1;
        end else begin
            st_edge = bus.start && !m_prev;
            m_prev  = bus.start;
            if (!m_run) begin
                if (st_edge) begin
                    m_run   = 1'b1;
                    m_phase = 1;
                end
            end else if (m_phase < 3) begin
                m_phase++;
            end else begin
                if (m_beat == 1)      m_beat = bus.short ? 1 : 2;
                else if (m_beat == 2) m_beat = bus.long ? 3 : 1;
                else                  m_beat = 1;
                if (halt) begin
                    m_run   = 1'b0;
                    m_phase = 0;
                end else begin
                    m_phase = 1;
                end
            end
        end
        #1;
        check();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Advance until the model shows the given beat/phase while running; bounded.
    task automatic wait_for(input int beat, input int phase, input string tag);
        int k;
        k = 0;
        while (!(m_run && m_beat == beat && m_phase == phase) && k < 30) begin
            tick();
            k++;
        end
        tests++;
        assert (k < 30) else begin
            fails++;
            $error("FAIL %s: not reached after %0d cycles, expected beat %0d phase %0d",
                   tag, k, beat, phase);
        end
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    initial begin
        clr       = 1'b1;
        bus.start = 1'b0;
        bus.short = 1'b0;
        bus.long  = 1'b0;
        bus.stop  = 1'b0;
`ifdef HD_TIMING_SSTEP_EN
        bus.sstep = 1'b0;
`endif
        ticks(2);
        clr = 1'b0;
        ticks(3);

        // Free-running with all controls low: 001,010,001,...
        pulse_start();
        ticks(14);

        // LONG held through the W[2] beat gives a W[3] beat.
        wait_for(1, 1, "reach_w1");
        bus.long = 1'b1;
        ticks(6);
        bus.long = 1'b0;
        ticks(9);

        // SHORT held keeps the sequencer in W[1].
        bus.short = 1'b1;
        ticks(15);
        bus.short = 1'b0;

        // STOP only at T3 of W[1]; then hold halted and resume at W[2].
        wait_for(1, 3, "reach_w1_t3");
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        ticks(10);
        pulse_start();
        ticks(4);

        // STOP and a START edge on the same T3 edge: STOP wins.
        wait_for(2, 3, "reach_w2_t3");
        bus.stop  = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.stop  = 1'b0;
        ticks(4);
        bus.start = 1'b0;
        tick();
        pulse_start();

        // CLR at T2 of W[2] with START held high: no run until a fresh rising edge.
        wait_for(2, 2, "reach_w2_t2");
        bus.start = 1'b1;
        clr       = 1'b1;
        tick();
        clr = 1'b0;
        ticks(6);
        bus.start = 1'b0;
        tick();
        pulse_start();
        ticks(5);

`ifdef HD_TIMING_SSTEP_EN
        // Single-step: one beat per START edge.
        wait_for(1, 3, "reach_sstep");
        bus.stop = 1'b1;
        tick();
        bus.stop  = 1'b0;
        clr       = 1'b1;
        tick();
        clr       = 1'b0;
        bus.sstep = 1'b1;
        tick();
        for (int s = 0; s < 3; s++) begin
            pulse_start();
            ticks(5);
        end
        bus.sstep = 1'b0;
`endif

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            clr = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 3) == 0) bus.start = ~bus.start;
            bus.short = $urandom_range(0, 2) == 0;
            bus.long  = $urandom_range(0, 1) == 0;
            bus.stop  = $urandom_range(0, 5) == 0;
`ifdef HD_TIMING_SSTEP_EN
            bus.sstep = $urandom_range(0, 7) == 0;
`endif
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
